// File: rtl/am_ask_pkg.sv
// am_ask_pkg -- types and constants shared by the AM/ASK modulator.
//   state_e     : ASK symbol FSM states (IDLE, SEND)
//   mode_e      : modulation select (AM = analog envelope, ASK = bit envelope)
//   MID         : offset-binary zero level
//   LUT_AW      : sine table index width
//   SINE_PEAK   : sine table amplitude
//   am_envelope : clamp(MID + ((am_in - MID) * depth >>> 8), 0, 255)
package am_ask_pkg;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
    typedef enum logic {AM = 1'b0, ASK = 1'b1} mode_e;

    localparam int unsigned MID       = 128;
    localparam int unsigned LUT_AW    = 8;
    localparam int unsigned SINE_PEAK = 127;

    function automatic logic [7:0] am_envelope(input logic [7:0] am_in,
                                               input logic [7:0] depth);
        logic signed [8:0]  centred;
        logic signed [17:0] prod;
        logic signed [17:0] sum;
        centred = $signed({1'b0, am_in}) - 9'sd128;
        prod    = 18'(centred) * 18'($signed({1'b0, depth}));
        sum     = 18'sd128 + (prod >>> 8);
        if (sum < 0)
            return 8'd0;
        else if (sum > 18'sd255)
            return 8'd255;
        else
            return sum[7:0];
    endfunction

endpackage

// File: rtl/am_ask_mod_sine_lut.sv
// sine_lut -- registered 256-point sine, amplitude +/-SINE_PEAK, built from a
// 64-entry quarter-wave ROM unfolded by quadrant symmetry.
//   clk  : clock (rising edge)
//   rst  : asynchronous active-high reset, clears the output to 0
//   idx  : phase index, LUT_AW bits (full circle = 2^LUT_AW)
//   sine : two's-complement sine sample, valid one cycle after idx
module sine_lut
    import am_ask_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] idx,
    output logic [7:0]        sine
);

    // round(127 * sin(2*pi*k/256)), k = 0..63
    localparam logic [6:0] QUARTER [64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,
         25,  28,  31,  34,  37,  40,  43,  46,
         49,  51,  54,  57,  60,  63,  65,  68,
         71,  73,  76,  78,  81,  83,  85,  88,
         90,  92,  94,  96,  98, 100, 102, 104,
        106, 107, 109, 111, 112, 113, 115, 116,
        117, 118, 120, 121, 122, 122, 123, 124,
        125, 125, 126, 126, 126, 127, 127, 127
    };

    logic [1:0] quad;
    logic [5:0] off;
    logic [6:0] mag;

    // Falling quadrants read the table mirrored (64 - off); off = 0 there is
    // the crest, which lies one entry beyond the stored quarter.
    always_comb begin
        quad = idx[LUT_AW-1 -: 2];
        off  = idx[LUT_AW-3:0];
        mag  = '0;
        if (!quad[0])
            mag = QUARTER[off];
        else if (off == '0)
            mag = 7'(SINE_PEAK);
        else
            mag = QUARTER[6'(7'd64 - {1'b0, off})];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sine <= '0;
        else
            sine <= quad[1] ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    end

endmodule

// File: rtl/am_ask_mod.sv
// am_ask_mod -- AM / ASK modulator: NCO sine carrier scaled by an envelope.
//   clk, rst              : clock, asynchronous active-high reset
//   mode                  : 0 = AM (envelope from am_in), 1 = ASK (from bits)
//   fcw                   : carrier frequency control word (PHASE_W bits)
//   mod_depth             : modulation depth 0..255
//   sym_len               : clocks per ASK symbol (0 treated as 1)
//   am_in                 : offset-binary baseband sample, 128 = zero
//   bit_in/bit_valid/bit_ready : ASK bit handshake
//   busy                  : high while an ASK symbol is being sent
//   d_out                 : offset-binary modulated sample, 3 cycles after
//                           the phase/envelope registers
// Build option: AM_ASK_MOD_PHASE_RST_EN clears the phase accumulator on every
// accepted bit (phase-coherent symbols); otherwise the carrier runs freely.
module am_ask_mod
    import am_ask_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int SYM_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [7:0]         mod_depth,
    input  logic [SYM_W-1:0]   sym_len,
    input  logic [7:0]         am_in,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic               busy,
    output logic [7:0]         d_out
);

    logic [PHASE_W-1:0] phase;
    state_e             state;
    logic [SYM_W-1:0]   remain;
    logic [SYM_W-1:0]   sym_cycles;
    logic [7:0]         env;
    logic [7:0]         env_d1;
    logic [7:0]         bit_env;
    logic [7:0]         sine;
    logic signed [16:0] prod;
    logic signed [7:0]  scaled;
    logic               is_ask;
    logic               accept;

    assign is_ask     = (mode_e'(mode) == ASK);
    assign sym_cycles = (sym_len == '0) ? SYM_W'(1) : sym_len;
    assign bit_env    = bit_in ? 8'hFF : (8'hFF - mod_depth);
    assign busy       = (state == SEND);
    assign accept     = bit_valid && bit_ready;

    // Combinational so the handshake is live from the first cycle after reset;
    // remain == 0 marks the last cycle of the current symbol.
    always_comb begin
        bit_ready = !rst && is_ask && (state == IDLE || remain == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            remain <= '0;
            env    <= '0;
        end else if (!is_ask) begin
            state  <= IDLE;
            remain <= '0;
            env    <= am_envelope(am_in, mod_depth);
        end else if (accept) begin
            state  <= SEND;
            remain <= sym_cycles - SYM_W'(1);
            env    <= bit_env;
        end else if (state == SEND && remain != '0) begin
            remain <= remain - SYM_W'(1);
        end else begin
            state  <= IDLE;
            remain <= '0;
            env    <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase <= '0;
`ifdef AM_ASK_MOD_PHASE_RST_EN
        else if (accept)
            phase <= '0;
`endif
        else
            phase <= phase + fcw;
    end

    // Stage 1: sine lookup (registered inside sine_lut); env is delayed to match.
    sine_lut u_sine_lut (
        .clk  (clk),
        .rst  (rst),
        .idx  (phase[PHASE_W-1 -: LUT_AW]),
        .sine (sine)
    );

    // |sine*env| <= 127*255, so the scaled product always fits in 8 signed bits.
    always_comb begin
        scaled = 8'(prod >>> 8);
    end

    // Stage 2: multiply, stage 3: offset add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_d1 <= '0;
            prod   <= '0;
            d_out  <= 8'(MID);
        end else begin
            env_d1 <= env;
            prod   <= 17'($signed(sine)) * 17'($signed({1'b0, env_d1}));
            d_out  <= scaled + 8'(MID);
        end
    end

endmodule

// File: tb/tb_am_ask_mod.sv
module tb_am_ask_mod;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [23:0] fcw;
    logic [7:0]  mod_depth;
    logic [15:0] sym_len;
    logic [7:0]  am_in;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic        busy;
    logic [7:0]  d_out;

    am_ask_mod #(.PHASE_W(24), .SYM_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .fcw       (fcw),
        .mod_depth (mod_depth),
        .sym_len   (sym_len),
        .am_in     (am_in),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .d_out     (d_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-cycle history of the phase word and envelope,
    // and the active symbol as a window of cycle numbers.
    int cyc = 0;
    int ph_hist  [MAXC];
    int env_hist [MAXC];
    bit rst_hist [MAXC];
    int d_log    [MAXC];
    int sym_start = 0;
    int sym_end   = -1;
    int sym_env   = 0;
    bit last_acc;
    int samp_d;
    bit samp_busy;
    bit samp_ready;

    function automatic int sine_ref(input int idx);
        real r;
        r = 127.0 * $sin(6.283185307179586 * real'(idx) / 256.0);
        if (r >= 0.0) return int'($floor(r + 0.5));
        else          return -int'($floor(-r + 0.5));
    endfunction

    function automatic int am_env_ref(input int a, input int md);
        int v;
        v = 128 + (((a - 128) * md) >>> 8);
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: inputs already driven; check outputs at the falling
    // edge, advance the model, then return 1 time unit after the rising edge.
    task automatic step();
        bit in_sym, exp_ready, exp_busy, acc, pipe_clear;
        int exp_d, next_ph, next_env, len;
        @(negedge clk);
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst) begin
            ph_hist[cyc]  = 0;
            env_hist[cyc] = 0;
            rst_hist[cyc] = 1'b1;
            sym_end       = -1;
        end
        in_sym    = (cyc >= sym_start) && (cyc <= sym_end);
        exp_busy  = in_sym && !rst;
        exp_ready = !rst && mode && (!in_sym || cyc == sym_end);
        pipe_clear = (cyc < 3);
        for (int k = 0; k <= 3; k++)
            if (cyc - k >= 0 && rst_hist[cyc - k]) pipe_clear = 1'b1;
        if (pipe_clear)
            exp_d = 128;
        else
            exp_d = 128 + ((sine_ref(ph_hist[cyc-3] >> 16) * env_hist[cyc-3]) >>> 8);

        samp_d     = int'(d_out);
        samp_busy  = busy;
        samp_ready = bit_ready;
        d_log[cyc] = samp_d;
        check("bit_ready", 32'(bit_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(exp_busy));
        check("d_out", 32'(d_out), 32'(exp_d));

        acc = bit_valid && exp_ready;
        last_acc = acc;
        if (!rst && !mode && in_sym) sym_end = cyc;
        if (acc) begin
            len       = (sym_len == 0) ? 1 : int'(sym_len);
            sym_start = cyc + 1;
            sym_end   = cyc + len;
            sym_env   = bit_in ? 255 : 255 - int'(mod_depth);
        end

        if (rst)
            next_ph = 0;
        else begin
            next_ph = (ph_hist[cyc] + int'(fcw)) & 32'h00FF_FFFF;
`ifdef AM_ASK_MOD_PHASE_RST_EN
            if (acc) next_ph = 0;
`endif
        end
        if (rst)
            next_env = 0;
        else if (!mode)
            next_env = am_env_ref(int'(am_in), int'(mod_depth));
        else if (cyc + 1 >= sym_start && cyc + 1 <= sym_end)
            next_env = sym_env;
        else
            next_env = 0;
        ph_hist[cyc+1]  = next_ph;
        env_hist[cyc+1] = next_env;
        rst_hist[cyc+1] = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mx, mn, n_acc, a1, a2, cnt, bad;
        rst = 1'b1; mode = 1'b1; fcw = 24'd262144; mod_depth = 8'd255;
        sym_len = 16'd16; am_in = 8'd128; bit_in = 1'b0; bit_valid = 1'b0;
        ph_hist[0] = 0; env_hist[0] = 0; rst_hist[0] = 1'b1;
        @(posedge clk); #1;

        // Reset, then release in ASK mode: ready immediately.
        repeat (3) step();
        rst = 1'b0;
        step();
        check("ready_after_reset", 32'(samp_ready), 32'd1);

        // AM at constant envelope: peak 191, trough 64.
        mode = 1'b0; fcw = 24'd262144; am_in = 8'd128; mod_depth = 8'd200;
        mx = 0; mn = 255;
        for (int i = 0; i < 80; i++) begin
            step();
            if (i >= 8) begin
                if (samp_d > mx) mx = samp_d;
                if (samp_d < mn) mn = samp_d;
            end
        end
        check("am_peak", 32'(mx), 32'd191);
        check("am_trough", 32'(mn), 32'd64);
        check("am_ready_low", 32'(samp_ready), 32'd0);

        // AM with random baseband, depth and carrier.
        for (int i = 0; i < 60; i++) begin
            am_in = 8'($urandom); mod_depth = 8'($urandom); fcw = 24'($urandom);
            step();
        end

        // ASK: bits 1,0 with valid held.
        mode = 1'b1; mod_depth = 8'd255; sym_len = 16'd16; fcw = 24'd1048576;
        bit_valid = 1'b1; bit_in = 1'b1;
        n_acc = 0; a1 = 0; a2 = 0;
        for (int i = 0; i < 100 && n_acc < 2; i++) begin
            step();
            if (last_acc) begin
                n_acc++;
                if (n_acc == 1) begin a1 = cyc - 1; bit_in = 1'b0; end
                else begin a2 = cyc - 1; bit_valid = 1'b0; end
            end
        end
        check("ask_accepts", 32'(n_acc), 32'd2);
        check("ask_ready_period", 32'(a2 - a1), 32'd16);
        repeat (24) step();
        mx = 0; bad = 0;
        for (int c = a1 + 4; c <= a1 + 19; c++) if (d_log[c] > mx) mx = d_log[c];
        for (int c = a2 + 4; c <= a2 + 19; c++) if (d_log[c] != 128) bad++;
        check("ask_peak_near_254", 32'(mx >= 250 && mx <= 254), 32'd1);
        check("ask_zero_symbol", 32'(bad), 32'd0);

        // Underrun: one bit, then valid dropped.
        bit_valid = 1'b1; bit_in = 1'b1; n_acc = 0;
        for (int i = 0; i < 20 && n_acc == 0; i++) begin
            step();
            if (last_acc) n_acc = 1;
        end
        check("underrun_accept", 32'(n_acc), 32'd1);
        bit_valid = 1'b0; cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (samp_busy) cnt++;
        end
        check("underrun_busy_len", 32'(cnt), 32'd16);
        check("underrun_ready_high", 32'(samp_ready), 32'd1);
        check("underrun_idle_mid", 32'(samp_d), 32'd128);

        // sym_len = 0: one-cycle symbols, ready stays high.
        sym_len = 16'd0; bit_valid = 1'b1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            bit_in = 1'($urandom); mod_depth = 8'($urandom);
            step();
            if (samp_ready) cnt++;
        end
        check("symlen0_ready_held", 32'(cnt), 32'd12);
        bit_valid = 1'b0;
        repeat (3) step();

        // Mode switch 1->0 at symbol cycle 5.
        sym_len = 16'd16; mod_depth = 8'd255; bit_valid = 1'b1; bit_in = 1'b1; n_acc = 0;
        for (int i = 0; i < 20 && n_acc == 0; i++) begin
            step();
            if (last_acc) n_acc = 1;
        end
        check("switch_accept", 32'(n_acc), 32'd1);
        bit_valid = 1'b0;
        repeat (4) step();
        mode = 1'b0; am_in = 8'd220;
        step();
        check("switch_busy_same_cycle", 32'(samp_busy), 32'd1);
        step();
        check("switch_idle_next", 32'(samp_busy), 32'd0);
        repeat (6) step();

        // Randomised mix with occasional reset.
        for (int i = 0; i < 400; i++) begin
            mode      = ($urandom_range(0, 19) != 0);
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            sym_len   = 16'($urandom_range(0, 4));
            mod_depth = 8'($urandom);
            am_in     = 8'($urandom);
            fcw       = 24'($urandom);
            rst       = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0; bit_valid = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
